// File: rtl/arm_pipe_pkg.sv
// arm_pipe_pkg: shared ID->EX bundle type and execute-command encodings
package arm_pipe_pkg;
    localparam int DATA_W = 32;
    localparam logic [3:0] EXE_MOV = 4'b0001;
    localparam logic [3:0] EXE_MVN = 4'b1001;
    localparam logic [3:0] EXE_ADD = 4'b0010;
    localparam logic [3:0] EXE_ADC = 4'b0011;
    localparam logic [3:0] EXE_SUB = 4'b0100;
    localparam logic [3:0] EXE_SBC = 4'b0101;
    localparam logic [3:0] EXE_AND = 4'b0110;
    localparam logic [3:0] EXE_ORR = 4'b0111;
    localparam logic [3:0] EXE_EOR = 4'b1000;
    localparam logic [3:0] EXE_CMP = 4'b0100;
    localparam logic [3:0] EXE_TST = 4'b0110;
    localparam logic [3:0] EXE_LDR = 4'b0010;
    localparam logic [3:0] EXE_STR = 4'b0010;
    typedef struct packed {
        logic              WB_EN;
        logic              MEM_R_EN;
        logic              MEM_W_EN;
        logic [3:0]        EXE_CMD;
        logic              B;
        logic              S;
        logic [DATA_W-1:0] PC;
        logic [DATA_W-1:0] Val_Rn;
        logic [DATA_W-1:0] Val_Rm;
        logic              Imm;
        logic [11:0]       Shift_operand;
        logic [23:0]       Signed_imm_24;
        logic [3:0]        Dest;
        logic [3:0]        SR;
        logic [3:0]        src1;
        logic [3:0]        src2;
    } id_ex_bundle_t;
endpackage

// File: rtl/id_ex_stage_reg_if.sv
// id_ex_stage_reg_if: ID-side and EX-side valid/ready handshake of the ID->EX register
interface id_ex_stage_reg_if;
    import arm_pipe_pkg::*;
    logic          in_valid;
    logic          in_ready;
    id_ex_bundle_t in_bundle;
    logic          out_valid;
    logic          out_ready;
    id_ex_bundle_t out_bundle;
    modport master (output in_valid, in_bundle, out_ready, input in_ready, out_valid, out_bundle);
    modport slave  (input in_valid, in_bundle, out_ready, output in_ready, out_valid, out_bundle);
endinterface

// File: rtl/pipe_skid_buf.sv
// pipe_skid_buf: two-entry valid/ready buffer with registered ready and synchronous clear
module pipe_skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o,
    output logic         skid_valid_o,
    output logic [W-1:0] skid_data_o
);
    logic         main_v_q, main_v_d, skid_v_q, skid_v_d;
    logic [W-1:0] main_q, main_d, skid_q, skid_d;
    logic         acc, cons;

    assign acc = in_valid_i & ~skid_v_q;
    assign cons = main_v_q & out_ready_i;

    always_comb begin
        main_v_d = main_v_q;
        skid_v_d = skid_v_q;
        main_d   = main_q;
        skid_d   = skid_q;
        if (clr_i) begin
            main_v_d = 1'b0;
            skid_v_d = 1'b0;
        end else if (skid_v_q) begin
            main_d   = cons ? skid_q : main_q;
            skid_v_d = ~cons;
        end else if (main_v_q) begin
            main_d   = (acc & cons) ? in_data_i : main_q;
            skid_d   = (acc & ~cons) ? in_data_i : skid_q;
            skid_v_d = acc & ~cons;
            main_v_d = acc | ~cons;
        end else begin
            main_d   = acc ? in_data_i : main_q;
            main_v_d = acc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_v_q <= 1'b0;
            skid_v_q <= 1'b0;
            main_q   <= '0;
            skid_q   <= '0;
        end else begin
            main_v_q <= main_v_d;
            skid_v_q <= skid_v_d;
            main_q   <= main_d;
            skid_q   <= skid_d;
        end
    end

    // ready is the inverted skid flop, so EX back-pressure never reaches ID combinationally
    assign in_ready_o   = ~skid_v_q;
    assign out_valid_o  = main_v_q;
    assign out_data_o   = main_q;
    assign skid_valid_o = skid_v_q;
    assign skid_data_o  = skid_q;
endmodule

// File: rtl/id_ex_stage_reg.sv
// id_ex_stage_reg: ID->EX pipeline register with skid buffer, branch flush and hazard taps
module id_ex_stage_reg
    import arm_pipe_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    id_ex_stage_reg_if.slave         bus,
    output logic [1:0]               pend_wb_en,
    output logic [7:0]               pend_dest
);
    logic          skid_v;
    id_ex_bundle_t skid_b;
    logic          unused_skid;

    pipe_skid_buf #(.W($bits(id_ex_bundle_t))) u_buf (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr_i        (flush),
        .in_valid_i   (bus.in_valid),
        .in_ready_o   (bus.in_ready),
        .in_data_i    (bus.in_bundle),
        .out_valid_o  (bus.out_valid),
        .out_ready_i  (bus.out_ready),
        .out_data_o   (bus.out_bundle),
        .skid_valid_o (skid_v),
        .skid_data_o  (skid_b)
    );

    assign pend_wb_en  = {skid_v & skid_b.WB_EN, bus.out_valid & bus.out_bundle.WB_EN};
    assign pend_dest   = {skid_b.Dest, bus.out_bundle.Dest};
    assign unused_skid = ^skid_b;
endmodule

// File: tb/tb_id_ex_stage_reg.sv
// tb_id_ex_stage_reg: directed plus random checks against a FIFO-queue reference model
module tb_id_ex_stage_reg;
    import arm_pipe_pkg::*;
    logic          clk = 1'b0;
    logic          rst_n, flush;
    logic [1:0]    pend_wb_en;
    logic [7:0]    pend_dest;
    int            checks = 0, failures = 0;
    id_ex_bundle_t q[$];

    id_ex_stage_reg_if bus();

    id_ex_stage_reg dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .bus        (bus),
        .pend_wb_en (pend_wb_en),
        .pend_dest  (pend_dest)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [157:0] obs, input logic [157:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic id_ex_bundle_t mk(input logic [31:0] pc, input logic wb, input logic [3:0] dest);
        logic [159:0]  r;
        id_ex_bundle_t b;
        r = {$urandom, $urandom, $urandom, $urandom, $urandom};
        b = r[157:0];
        b.PC = pc;
        b.WB_EN = wb;
        b.Dest = dest;
        return b;
    endfunction

    task automatic drive(input logic v, input id_ex_bundle_t b, input logic rdy, input logic fl);
        bus.in_valid  = v;
        bus.in_bundle = b;
        bus.out_ready = rdy;
        flush         = fl;
    endtask

    // model: the block is a 2-deep FIFO; flush empties it, accept needs room, consume needs data
    task automatic check_model();
        logic [1:0] ewb;
        ewb = {q.size() > 1 ? q[1].WB_EN : 1'b0, q.size() > 0 ? q[0].WB_EN : 1'b0};
        chk("out_valid", 158'(bus.out_valid), 158'(q.size() > 0));
        chk("in_ready", 158'(bus.in_ready), 158'(q.size() < 2));
        chk("pend_wb_en", 158'(pend_wb_en), 158'(ewb));
        if (q.size() > 0) begin
            chk("out_bundle", 158'(bus.out_bundle), 158'(q[0]));
            chk("pend_dest_main", 158'(pend_dest[3:0]), 158'(q[0].Dest));
        end
        if (q.size() > 1) chk("pend_dest_skid", 158'(pend_dest[7:4]), 158'(q[1].Dest));
    endtask

    task automatic cyc();
        bit            acc, cons, fl;
        id_ex_bundle_t b;
        acc  = bus.in_valid && q.size() < 2;
        cons = q.size() > 0 && bus.out_ready;
        fl   = flush;
        b    = bus.in_bundle;
        @(posedge clk);
        if (fl) q.delete();
        else begin
            if (cons) void'(q.pop_front());
            if (acc) q.push_back(b);
        end
        #1;
        check_model();
    endtask

    initial begin
        logic [31:0] pc;
        rst_n = 1'b0;
        drive(1'b1, mk(32'h4, 1'b1, 4'd2), 1'b1, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 158'(bus.out_valid), 158'(0));
        chk("rst_in_ready", 158'(bus.in_ready), 158'(1));
        chk("rst_pend_wb_en", 158'(pend_wb_en), 158'(0));
        chk("rst_out_bundle", 158'(bus.out_bundle), 158'(0));
        rst_n = 1'b1;
        cyc();
        chk("first_pc", 158'(bus.out_bundle.PC), 158'(32'h4));
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, mk(32'(i * 4), 1'b0, 4'(i)), 1'b1, 1'b0);
            cyc();
            chk("stream_pc", 158'(bus.out_bundle.PC), 158'(i * 4));
            chk("stream_ready", 158'(bus.in_ready), 158'(1));
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        cyc();
        drive(1'b1, mk(32'h8, 1'b0, 4'd1), 1'b1, 1'b0);
        cyc();
        drive(1'b1, mk(32'hC, 1'b0, 4'd2), 1'b0, 1'b0);
        cyc();
        chk("bp_ready_low", 158'(bus.in_ready), 158'(0));
        chk("bp_hold_pc", 158'(bus.out_bundle.PC), 158'(32'h8));
        drive(1'b0, '0, 1'b1, 1'b0);
        cyc();
        chk("bp_second_pc", 158'(bus.out_bundle.PC), 158'(32'hC));
        cyc();
        chk("bp_drained", 158'(bus.out_valid), 158'(0));
        drive(1'b1, mk(32'h10, 1'b1, 4'd3), 1'b0, 1'b0);
        cyc();
        drive(1'b1, mk(32'h14, 1'b1, 4'd4), 1'b0, 1'b0);
        cyc();
        chk("fl_full", 158'(bus.in_ready), 158'(0));
        drive(1'b1, mk(32'h18, 1'b1, 4'd6), 1'b0, 1'b1);
        cyc();
        chk("fl_out_valid", 158'(bus.out_valid), 158'(0));
        chk("fl_pend", 158'(pend_wb_en), 158'(0));
        chk("fl_ready", 158'(bus.in_ready), 158'(1));
        drive(1'b0, '0, 1'b1, 1'b0);
        repeat (2) begin
            cyc();
            chk("fl_no_0x18", 158'(bus.out_valid), 158'(0));
        end
        drive(1'b1, mk(32'h20, 1'b1, 4'd8), 1'b0, 1'b0);
        cyc();
        drive(1'b1, mk(32'h24, 1'b1, 4'd9), 1'b0, 1'b1);
        cyc();
        drive(1'b0, '0, 1'b1, 1'b0);
        cyc();
        chk("fl_accept_dropped", 158'(bus.out_valid), 158'(0));
        drive(1'b1, mk(32'h30, 1'b1, 4'd5), 1'b0, 1'b0);
        cyc();
        drive(1'b1, mk(32'h34, 1'b0, 4'd7), 1'b0, 1'b0);
        cyc();
        drive(1'b0, '0, 1'b0, 1'b0);
        chk("tap_wb_en", 158'(pend_wb_en), 158'(2'b01));
        chk("tap_dest", 158'(pend_dest), 158'(8'h75));
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 158'(bus.out_valid), 158'(0));
        chk("arst_pend", 158'(pend_wb_en), 158'(0));
        chk("arst_ready", 158'(bus.in_ready), 158'(1));
        q.delete();
        #1 rst_n = 1'b1;
        cyc();
        pc = 32'h100;
        for (int i = 0; i < 600; i++) begin
            if (!(bus.in_valid && !bus.in_ready)) begin
                bus.in_valid  = ($urandom % 3) != 0;
                bus.in_bundle = mk(pc, 1'($urandom), 4'($urandom));
                pc += 4;
            end
            bus.out_ready = 1'($urandom);
            flush = ($urandom % 12) == 0;
            cyc();
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        repeat (3) cyc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
